// File: rtl/adc_capture.sv
// -----------------------------------------------------------------------------
// adc_capture
//   Receive-side ADC front end. Drives the ADC sample clock and power-down pin.
//   It captures parallel ADC samples on a fixed divider phase and buffers them
//   in a first-word-fall-through FIFO for a valid/ready reader.
//
// Ports
//   clk           in   system clock, all logic on posedge
//   rst           in   synchronous reset, active-low
//   enable        in   1 = power up and sample, 0 = stop and power down
//   adc_data      in   parallel ADC output bus (DATA_W)
//   adc_clk       out  ADC sample clock (registered, toggles only in RUN)
//   adc_pwrdn     out  ADC power-down, 1 = powered down (registered)
//   rd_data       out  FIFO head sample (first-word-fall-through)
//   rd_valid      out  FIFO not empty
//   rd_ready      in   reader accepts rd_data this cycle
//   fifo_level    out  samples stored, 0..2**FIFO_AW
//   overflow      out  sticky: a sample was dropped because the FIFO was full
//   overflow_clr  in   clears overflow (a same-cycle overflow event wins)
//   test_mode     in   only with ADC_TEST_PATTERN_EN: capture a ramp instead
//   running       out  1 while in RUN
//
// Optional feature macro: ADC_TEST_PATTERN_EN (adds test_mode and ramp logic).
// -----------------------------------------------------------------------------
module adc_capture #(
  parameter int DATA_W   = 10,
  parameter int CLK_DIV  = 4,
  parameter int WAKE_CYC = 16,
  parameter int FIFO_AW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_clk,
  output logic              adc_pwrdn,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [FIFO_AW:0]  fifo_level,
  output logic              overflow,
  input  logic              overflow_clr,
`ifdef ADC_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic              running
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int WAKE_W = $clog2(WAKE_CYC + 1);
  localparam int DEPTH  = 1 << FIFO_AW;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAKE = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYC - 1);
  localparam logic [FIFO_AW:0]  LVL_FULL  = (FIFO_AW + 1)'(DEPTH);

  // Control registers
  logic [1:0]         state_q,    state_d;
  logic [WAKE_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic [DIV_W-1:0]   div_q,      div_d;
  logic               adc_clk_q,  adc_clk_d;
  logic               pwrdn_q,    pwrdn_d;
  logic               cap_vld_q,  cap_vld_d;
  logic [DATA_W-1:0]  cap_data_q, cap_data_d;
  logic [DATA_W-1:0]  ramp_q,     ramp_d;

  // FIFO registers
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [FIFO_AW:0]   level_q,    level_d;
  logic               valid_q,    valid_d;
  logic               ovf_q,      ovf_d;

  logic               pop_s, full_s, push_ok_s, ovf_evt_s, run_entry_s;
  logic [DATA_W-1:0]  sample_s;

  // Power-sequencing FSM: IDLE -> WAKE (WAKE_CYC cycles) -> RUN
  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      ST_IDLE: begin
        wake_cnt_d = {WAKE_W{1'b0}};
        if (enable) begin
          state_d = ST_WAKE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAKE: begin
        if (!enable) begin
          state_d    = ST_IDLE;
          wake_cnt_d = {WAKE_W{1'b0}};
        end else if (wake_cnt_q == WAKE_LAST) begin
          state_d    = ST_RUN;
          wake_cnt_d = {WAKE_W{1'b0}};
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_W'(1'b1);
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wake_cnt_d = {WAKE_W{1'b0}};
      end
    endcase
  end

  // Divider, registered ADC pins and capture register
  always_comb begin
    run_entry_s = (state_q != ST_RUN) && (state_d == ST_RUN);
    // The divider restarts on RUN entry so the first sample lands CLK_DIV cycles in.
    if (state_d != ST_RUN) begin
      div_d = {DIV_W{1'b0}};
    end else if (run_entry_s || (div_q == DIV_LAST)) begin
      div_d = {DIV_W{1'b0}};
    end else begin
      div_d = div_q + DIV_W'(1'b1);
    end
    // adc_clk is computed from next-state count so the pin lines up with the count.
    adc_clk_d = (state_d == ST_RUN) && (div_d >= DIV_HALF);
    pwrdn_d   = (state_d == ST_IDLE);

`ifdef ADC_TEST_PATTERN_EN
    if (test_mode) begin
      sample_s = ramp_q;
    end else begin
      sample_s = adc_data;
    end
`else
    sample_s = adc_data;
`endif

    // Capture is decided by the current state, so a sample taken on the edge
    // that leaves RUN is still pushed into the FIFO one cycle later.
    cap_vld_d = (state_q == ST_RUN) && (div_q == DIV_LAST);
    if (cap_vld_d) begin
      cap_data_d = sample_s;
    end else begin
      cap_data_d = cap_data_q;
    end

`ifdef ADC_TEST_PATTERN_EN
    if (run_entry_s) begin
      ramp_d = {DATA_W{1'b0}};
    end else if (cap_vld_d) begin
      ramp_d = ramp_q + DATA_W'(1'b1);
    end else begin
      ramp_d = ramp_q;
    end
`else
    ramp_d = {DATA_W{1'b0}};
`endif
  end

  // FIFO push/pop arbitration, level and sticky overflow
  always_comb begin
    pop_s  = (level_q != {(FIFO_AW + 1){1'b0}}) && rd_ready;
    full_s = (level_q == LVL_FULL);
    // A pop on the same edge frees the slot, so a full FIFO still takes the write.
    push_ok_s = cap_vld_q && (!full_s || pop_s);
    ovf_evt_s = cap_vld_q && full_s && !pop_s;

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + (FIFO_AW + 1)'(1'b1);
      2'b01:   level_d = level_q - (FIFO_AW + 1)'(1'b1);
      default: level_d = level_q;
    endcase
    valid_d = (level_d != {(FIFO_AW + 1){1'b0}});

    if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State register update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wake_cnt_q <= {WAKE_W{1'b0}};
      div_q      <= {DIV_W{1'b0}};
      adc_clk_q  <= 1'b0;
      pwrdn_q    <= 1'b1;
      cap_vld_q  <= 1'b0;
      cap_data_q <= {DATA_W{1'b0}};
      ramp_q     <= {DATA_W{1'b0}};
      wr_ptr_q   <= {FIFO_AW{1'b0}};
      rd_ptr_q   <= {FIFO_AW{1'b0}};
      level_q    <= {(FIFO_AW + 1){1'b0}};
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      div_q      <= div_d;
      adc_clk_q  <= adc_clk_d;
      pwrdn_q    <= pwrdn_d;
      cap_vld_q  <= cap_vld_d;
      cap_data_q <= cap_data_d;
      ramp_q     <= ramp_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers and level define validity
  always_ff @(posedge clk) begin
    if (rst && push_ok_s) begin
      mem_q[wr_ptr_q] <= cap_data_q;
    end
  end

  assign adc_clk    = adc_clk_q;
  assign adc_pwrdn  = pwrdn_q;
  assign rd_data    = mem_q[rd_ptr_q];
  assign rd_valid   = valid_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign running    = (state_q == ST_RUN);

endmodule

// File: tb/tb_adc_capture.sv
// -----------------------------------------------------------------------------
// tb_adc_capture
//   Self-checking bench for adc_capture. A behavioural model (mode + cycle
//   count in mode, a sample queue, a sticky flag) predicts every output each
//   cycle. Directed phases pin the model with literal values. A randomized
//   phase then exercises resets, enable toggles, backpressure and clears.
// -----------------------------------------------------------------------------
module tb_adc_capture;
  localparam int DATA_W   = 10;
  localparam int CLK_DIV  = 4;
  localparam int WAKE_CYC = 16;
  localparam int FIFO_AW  = 4;
  localparam int DEPTH    = 16;

  logic              clk = 1'b0;
  logic              rst, enable, rd_ready, overflow_clr, test_mode;
  logic [DATA_W-1:0] adc_data;
  logic              adc_clk, adc_pwrdn, rd_valid, overflow, running;
  logic [DATA_W-1:0] rd_data;
  logic [FIFO_AW:0]  fifo_level;

  always #5 clk = ~clk;

  adc_capture #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .WAKE_CYC(WAKE_CYC), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_data(adc_data),
    .adc_clk(adc_clk), .adc_pwrdn(adc_pwrdn), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .fifo_level(fifo_level), .overflow(overflow),
    .overflow_clr(overflow_clr),
`ifdef ADC_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .running(running)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=IDLE 1=WAKE 2=RUN, m_t = cycles spent in mode
  int                m_mode = 0;
  int                m_t    = 0;
  bit                m_pend = 1'b0;
  logic [DATA_W-1:0] m_pval = '0;
  logic [DATA_W-1:0] m_ramp = '0;
  logic [DATA_W-1:0] m_q[$];
  bit                m_ovf  = 1'b0;

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_mode = 0; m_t = 0; m_pend = 1'b0; m_q.delete(); m_ovf = 1'b0; m_ramp = '0;
    end else begin
      bit drop;
      drop = 1'b0;
      if (m_q.size() != 0 && rd_ready) void'(m_q.pop_front());
      if (m_pend) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_pval);
        else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      m_pend = (m_mode == 2) && ((m_t % CLK_DIV) == CLK_DIV - 1);
      if (m_pend) begin
        m_pval = test_mode ? m_ramp : adc_data;
        m_ramp = m_ramp + 1'b1;
      end
      case (m_mode)
        0: if (enable) begin m_mode = 1; m_t = 0; end
        1: begin
          if (!enable) m_mode = 0;
          else if (m_t == WAKE_CYC - 1) begin m_mode = 2; m_t = 0; m_ramp = '0; end
          else m_t++;
        end
        default: if (!enable) m_mode = 0; else m_t++;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("adc_pwrdn",  {31'd0, adc_pwrdn},  (m_mode == 0) ? 32'd1 : 32'd0);
      chk("running",    {31'd0, running},    (m_mode == 2) ? 32'd1 : 32'd0);
      chk("adc_clk",    {31'd0, adc_clk},
          (m_mode == 2 && (m_t % CLK_DIV) >= CLK_DIV / 2) ? 32'd1 : 32'd0);
      chk("rd_valid",   {31'd0, rd_valid},   (m_q.size() != 0) ? 32'd1 : 32'd0);
      chk("fifo_level", {27'd0, fifo_level}, m_q.size());
      chk("overflow",   {31'd0, overflow},   {31'd0, m_ovf});
      if (m_q.size() != 0) chk("rd_data", {22'd0, rd_data}, {22'd0, m_q[0]});
    end
  end

  int                n;
  int                maxlvl;
  logic [DATA_W-1:0] next_val;
  logic              prev_clk;

  // Changes adc_data after each adc_clk falling edge, advancing a counter
  task automatic stream_cycles(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (prev_clk && !adc_clk) begin
        adc_data = next_val;
        next_val = next_val + 1'b1;
      end
      prev_clk = adc_clk;
      if (fifo_level > maxlvl) maxlvl = fifo_level;
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; adc_data = 10'h2A5; rd_ready = 1'b0;
    overflow_clr = 1'b0; test_mode = 1'b0;
    next_val = 10'h000; prev_clk = 1'b0; maxlvl = 0;

    // Reset held 3 cycles with enable high
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_pwrdn",  {31'd0, adc_pwrdn}, 32'd1);
    chk("rst_adcclk", {31'd0, adc_clk},   32'd0);
    chk("rst_valid",  {31'd0, rd_valid},  32'd0);
    chk("rst_level",  {27'd0, fifo_level}, 32'd0);
    chk("rst_ovf",    {31'd0, overflow},  32'd0);

    // Bring-up
    rst = 1'b1;
    @(negedge clk);
    chk("wake_pwrdn",   {31'd0, adc_pwrdn}, 32'd0);
    chk("wake_running", {31'd0, running},   32'd0);
    n = 1;
    while (!running && n < 100) begin @(negedge clk); n++; end
    chk("edges_to_run", n, 32'd17);
    n = 0;
    while (!rd_valid && n < 50) begin @(negedge clk); n++; end
    chk("run_to_valid", n, 32'd5);
    chk("first_sample", {22'd0, rd_data}, 32'h2A5);

    // Streaming with reader always ready
    rd_ready = 1'b1;
    stream_cycles(160);
    chk("stream_lvl_le2", (maxlvl <= 2) ? 32'd1 : 32'd0, 32'd1);

    // Overflow: 20 samples with no reads
    rd_ready = 1'b0;
    stream_cycles(20 * CLK_DIV + 2);
    chk("ovf_level", {27'd0, fifo_level}, 32'd16);
    chk("ovf_flag",  {31'd0, overflow},   32'd1);
    n = 0;
    while (m_pend && n < 10) begin @(negedge clk); n++; end
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO, pop on a write cycle
    n = 0;
    while (!m_pend && n < 10) begin @(negedge clk); n++; end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    chk("fullpop_level", {27'd0, fifo_level}, 32'd16);
    chk("fullpop_ovf",   {31'd0, overflow},   32'd0);

    // Stop mid-RUN and drain in IDLE
    enable = 1'b0;
    @(negedge clk);
    chk("stop_pwrdn",   {31'd0, adc_pwrdn}, 32'd1);
    chk("stop_running", {31'd0, running},   32'd0);
    rd_ready = 1'b1;
    n = 0;
    while (rd_valid && n < 40) begin @(negedge clk); n++; end
    chk("drained_level", {27'd0, fifo_level}, 32'd0);

`ifdef ADC_TEST_PATTERN_EN
    begin
      bit                seen_wrap;
      logic [DATA_W-1:0] last;
      seen_wrap = 1'b0; last = '0;
      test_mode = 1'b1; enable = 1'b1;
      for (int i = 0; i < 1040 * CLK_DIV; i++) begin
        @(negedge clk);
        if (rd_valid) begin
          if (last == 10'h3FF && rd_data == 10'h000) seen_wrap = 1'b1;
          last = rd_data;
        end
      end
      chk("ramp_wrap", {31'd0, seen_wrap}, 32'd1);
      test_mode = 1'b0;
    end
`endif

    // Randomized phase; the per-cycle model check does the work
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      adc_data     = DATA_W'($urandom);
      rst          = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      if ((i / 500) % 2 == 0) rd_ready = ($urandom_range(0, 3) == 0);
      else rd_ready = ($urandom_range(0, 3) != 0);
      overflow_clr = ($urandom_range(0, 39) == 0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
